pc_sequencer: RTL and testbench

Parametrised program-sequencing unit that replaces the fixed 8-bit program counter in the CPU datapath. It generates the fetch address each cycle and supports variable-length increment, absolute jump, PC-relative branch, and call/return through an internal hardware return-address stack. It sits between the control unit, which supplies the per-cycle op strobes, and instruction memory, which is addressed by pc. Stack error conditions are flagged to the control unit as sticky errors.

---
 rtl/pc_sequencer_if.sv | 43 ++++
 rtl/pc_sequencer.sv | 116 +++++++++++
 tb/tb_pc_sequencer.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : pc_sequencer_if                                           |
// | Brief    : Control-unit <-> program sequencer strobe/status bundle   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
interface pc_sequencer_if #(
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4,
    parameter int INC_W       = 2
);
    localparam int c_SP_W = $clog2(STACK_DEPTH + 1);

    logic              halt;
    logic              jump_en;
    logic [ADDR_W-1:0] jump_addr;
    logic              branch_en;
    logic [ADDR_W-1:0] branch_off;
    logic              call_en;
    logic [ADDR_W-1:0] call_addr;
    logic              ret_en;
    logic [INC_W-1:0]  inc_len;
    logic              clear_err;
    logic [ADDR_W-1:0] pc;
    logic [c_SP_W-1:0] sp;
    logic              stack_full;
    logic              stack_empty;
    logic              overflow_err;
    logic              underflow_err;

    modport master (
        output halt, jump_en, jump_addr, branch_en, branch_off,
               call_en, call_addr, ret_en, inc_len, clear_err,
        input  pc, sp, stack_full, stack_empty, overflow_err, underflow_err
    );

    modport slave (
        input  halt, jump_en, jump_addr, branch_en, branch_off,
               call_en, call_addr, ret_en, inc_len, clear_err,
        output pc, sp, stack_full, stack_empty, overflow_err, underflow_err
    );
endinterface
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : pc_sequencer                                              |
// | Brief    : PC generator with inc/jump/branch and call/ret stack      |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module pc_sequencer #(
    parameter int          ADDR_W      = 8,
    parameter int          STACK_DEPTH = 4,
    parameter int          INC_W       = 2,
    parameter int unsigned RESET_ADDR  = 0
) (
    input  wire logic        clk,
    input  wire logic        reset,
    pc_sequencer_if.slave    bus
);
    localparam int c_SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int c_IDX_W = $clog2(STACK_DEPTH);
    localparam logic [ADDR_W-1:0] c_RESET_PC = ADDR_W'(RESET_ADDR);

    logic [ADDR_W-1:0]  r_pc;
    logic [c_SP_W-1:0]  r_sp;
    logic [ADDR_W-1:0]  r_stack [STACK_DEPTH];
    logic               r_ovf;
    logic               r_unf;

    logic [ADDR_W-1:0]  w_seq_pc;
    logic [ADDR_W-1:0]  w_pc_nxt;
    logic [c_SP_W-1:0]  w_sp_nxt;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_ovf_set;
    logic               w_unf_set;
    logic [c_IDX_W-1:0] w_push_idx;
    logic [c_IDX_W-1:0] w_top_idx;

    assign w_seq_pc   = r_pc + ADDR_W'(bus.inc_len);
    assign w_full     = (r_sp == c_SP_W'(STACK_DEPTH));
    assign w_empty    = (r_sp == '0);
    assign w_push_idx = c_IDX_W'(r_sp);
    assign w_top_idx  = c_IDX_W'(r_sp - c_SP_W'(1));

    // Strict priority: ret > call > jump > branch > advance; a rejected
    // call/ret still advances so the fetch stream never stalls on an error.
    always_comb begin
        w_pc_nxt  = r_pc;
        w_sp_nxt  = r_sp;
        w_push    = 1'b0;
        w_ovf_set = 1'b0;
        w_unf_set = 1'b0;
        if (!bus.halt) begin
            if (bus.ret_en) begin
                if (!w_empty) begin
                    w_pc_nxt = r_stack[w_top_idx];
                    w_sp_nxt = r_sp - c_SP_W'(1);
                end else begin
                    w_unf_set = 1'b1;
                    w_pc_nxt  = w_seq_pc;
                end
            end else if (bus.call_en) begin
                if (!w_full) begin
                    w_push   = 1'b1;
                    w_sp_nxt = r_sp + c_SP_W'(1);
                    w_pc_nxt = bus.call_addr;
                end else begin
                    w_ovf_set = 1'b1;
                    w_pc_nxt  = w_seq_pc;
                end
            end else if (bus.jump_en) begin
                w_pc_nxt = bus.jump_addr;
            end else if (bus.branch_en) begin
                w_pc_nxt = r_pc + bus.branch_off;
            end else begin
                w_pc_nxt = w_seq_pc;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc  <= c_RESET_PC;
            r_sp  <= '0;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                r_stack[i] <= '0;
            end
        end else begin
            r_pc <= w_pc_nxt;
            r_sp <= w_sp_nxt;
            if (w_push) begin
                r_stack[w_push_idx] <= w_seq_pc;
            end
            // A fresh error outranks a simultaneous clear.
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (bus.clear_err) begin
                r_ovf <= 1'b0;
            end
            if (w_unf_set) begin
                r_unf <= 1'b1;
            end else if (bus.clear_err) begin
                r_unf <= 1'b0;
            end
        end
    end

    assign bus.pc            = r_pc;
    assign bus.sp            = r_sp;
    assign bus.stack_full    = w_full;
    assign bus.stack_empty   = w_empty;
    assign bus.overflow_err  = r_ovf;
    assign bus.underflow_err = r_unf;
endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_pc_sequencer                                           |
// | Brief    : Random + directed scoreboard bench for pc_sequencer       |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_pc_sequencer;
    localparam int c_DEPTH = 4;

    typedef struct {
        logic [7:0] pc;
        int         sp;
        logic       full;
        logic       empty;
        logic       ovf;
        logic       unf;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    pc_sequencer_if #(.ADDR_W(8), .STACK_DEPTH(c_DEPTH), .INC_W(2)) bus ();

    pc_sequencer #(.ADDR_W(8), .STACK_DEPTH(c_DEPTH), .INC_W(2), .RESET_ADDR(0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    exp_t exp_q[$];

    // Reference state: plain byte PC and a queue used as the return stack.
    logic [7:0] m_pc;
    logic [7:0] m_stack[$];
    logic       m_ovf;
    logic       m_unf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        else n_pass++;
    endtask

    task automatic model_reset();
        m_pc = 8'h00;
        m_stack.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic check_now(input string tag, input exp_t e);
        chk({tag, ".pc"},    32'(bus.pc),            32'(e.pc));
        chk({tag, ".sp"},    32'(bus.sp),            32'(e.sp));
        chk({tag, ".full"},  32'(bus.stack_full),    32'(e.full));
        chk({tag, ".empty"}, 32'(bus.stack_empty),   32'(e.empty));
        chk({tag, ".ovf"},   32'(bus.overflow_err),  32'(e.ovf));
        chk({tag, ".unf"},   32'(bus.underflow_err), 32'(e.unf));
    endtask

    function automatic exp_t model_snapshot();
        exp_t e;
        e.pc    = m_pc;
        e.sp    = m_stack.size();
        e.full  = (m_stack.size() == c_DEPTH);
        e.empty = (m_stack.size() == 0);
        e.ovf   = m_ovf;
        e.unf   = m_unf;
        return e;
    endfunction

    // Drive one cycle of strobes and queue the state expected after the edge.
    task automatic step(input bit h, input bit r, input bit c, input bit j, input bit b,
                        input logic [7:0] ja, input logic [7:0] bo, input logic [7:0] ca,
                        input logic [1:0] inc, input bit clr);
        logic [7:0] seq;
        bit ovf_set, unf_set;
        @(negedge clk);
        bus.halt = h; bus.ret_en = r; bus.call_en = c; bus.jump_en = j; bus.branch_en = b;
        bus.jump_addr = ja; bus.branch_off = bo; bus.call_addr = ca;
        bus.inc_len = inc; bus.clear_err = clr;
        seq = m_pc + {6'b0, inc};
        ovf_set = 1'b0;
        unf_set = 1'b0;
        if (!h) begin
            if (r) begin
                if (m_stack.size() > 0) m_pc = m_stack.pop_back();
                else begin unf_set = 1'b1; m_pc = seq; end
            end else if (c) begin
                if (m_stack.size() < c_DEPTH) begin m_stack.push_back(seq); m_pc = ca; end
                else begin ovf_set = 1'b1; m_pc = seq; end
            end else if (j) m_pc = ja;
            else if (b) m_pc = m_pc + bo;
            else m_pc = seq;
        end
        if (ovf_set) m_ovf = 1'b1; else if (clr) m_ovf = 1'b0;
        if (unf_set) m_unf = 1'b1; else if (clr) m_unf = 1'b0;
        exp_q.push_back(model_snapshot());
    endtask

    task automatic adv(input logic [1:0] inc);          step(0,0,0,0,0, 8'h00, 8'h00, 8'h00, inc, 0); endtask
    task automatic jmp(input logic [7:0] a);            step(0,0,0,1,0, a,     8'h00, 8'h00, 2'd1, 0); endtask
    task automatic br(input logic [7:0] off);           step(0,0,0,0,1, 8'h00, off,   8'h00, 2'd1, 0); endtask
    task automatic call(input logic [7:0] a, input logic [1:0] inc) ; step(0,0,1,0,0, 8'h00, 8'h00, a, inc, 0); endtask
    task automatic ret(input logic [1:0] inc, input bit clr); step(0,1,0,0,0, 8'h00, 8'h00, 8'h00, inc, clr); endtask

    // Monitor: state is presented every cycle; compare one queued entry per edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_now("cyc", e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.halt = 1'b1; bus.ret_en = 0; bus.call_en = 0; bus.jump_en = 0; bus.branch_en = 0;
        bus.jump_addr = 0; bus.branch_off = 0; bus.call_addr = 0; bus.inc_len = 0; bus.clear_err = 0;
        model_reset();
        #2;
        check_now("reset", model_snapshot());
        @(negedge clk);
        reset = 1'b0;

        // Linear advance: 0,1,2,3,4,5,7,9,11
        repeat (5) adv(2'd1);
        repeat (3) adv(2'd2);

        // Wrap in both directions
        jmp(8'hFE); adv(2'd3);
        jmp(8'h05); br(8'hFB); br(8'hFF);

        // Nested call / return
        jmp(8'h10); call(8'h40, 2'd2); call(8'h80, 2'd1);
        ret(2'd1, 0); ret(2'd1, 0);

        // Fill, overflow, then pop the fourth pushed address
        jmp(8'h00);
        call(8'h20, 2'd1); call(8'h50, 2'd2); call(8'h60, 2'd3); call(8'h20, 2'd1);
        call(8'h99, 2'd1);
        ret(2'd1, 0);
        repeat (3) ret(2'd1, 0);

        // Underflow and sticky clear
        jmp(8'h30); ret(2'd1, 0);
        step(0,0,0,0,0, 8'h00, 8'h00, 8'h00, 2'd1, 1);
        ret(2'd1, 1);
        step(0,0,0,0,0, 8'h00, 8'h00, 8'h00, 2'd1, 1);

        // Priority, halt freeze, async reset with sp=3
        call(8'h11, 2'd1); call(8'h22, 2'd1); call(8'h33, 2'd1);
        step(0,1,1,1,1, 8'hAA, 8'h05, 8'hBB, 2'd1, 0);
        call(8'h44, 2'd2);
        step(1,1,1,1,1, 8'hAA, 8'h05, 8'hBB, 2'd3, 0);
        step(1,1,1,1,1, 8'hCC, 8'h07, 8'hDD, 2'd2, 0);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        check_now("async_rst", model_snapshot());
        @(negedge clk);
        reset = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0,
                 8'($urandom), 8'($urandom), 8'($urandom), 2'($urandom), $urandom_range(0, 9) == 0);
        end

        repeat (3) @(posedge clk);
        #2;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
